// File: rtl/sobel_stream_5x5.sv
`default_nettype none
// ============================================================================
//  Module      : sobel_stream_5x5
//  Description : Streaming 5x5 Sobel edge filter. Raster-order pixels enter
//                through a ready/valid port, four line buffers supply the
//                upper rows of a 5x5 register window, and a 3-stage pipeline
//                produces |X|, |Y| or |X|+|Y| (shifted, saturated) results
//                through a ready/valid output port.
//
//  Ports       : clk      rising-edge clock
//                rst      asynchronous active-high reset
//                mode     00=X, 01=Y, 10=|X|+|Y|, 11=X; latched on sof beats
//                s_valid  input pixel valid
//                s_ready  block can accept a pixel
//                s_sof    first pixel of a frame (col 0, row 0)
//                s_pixel  input pixel, DATA_W bits unsigned
//                m_valid  output pixel valid
//                m_ready  downstream accepts output
//                m_pixel  filtered pixel, DATA_W bits
//
//  Revision    : 1.0  initial release
// ============================================================================
module sobel_stream_5x5 #(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 640,
    parameter int SHIFT  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        mode,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic              s_sof,
    input  logic [DATA_W-1:0] s_pixel,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_pixel
);

    localparam int                  c_sum_w    = DATA_W + 8;
    localparam int                  c_col_w    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam logic [c_col_w-1:0]  c_col_last = c_col_w'(IMG_W - 1);
    localparam logic [c_col_w-1:0]  c_col_four = c_col_w'(4);
    localparam logic [2:0]          c_row_full = 3'd4;
    localparam logic [c_sum_w-1:0]  c_pix_max  = c_sum_w'((2 ** DATA_W) - 1);
    localparam logic [1:0]          c_mode_y   = 2'b01;
    localparam logic [1:0]          c_mode_mag = 2'b10;

    // ------------------------------------------------------------------
    // Flow control
    // ------------------------------------------------------------------
    logic r_m_valid;
    logic [DATA_W-1:0] r_m_pixel;
    logic w_stall;
    logic w_accept;

    // A held output that downstream refuses freezes everything upstream.
    assign w_stall  = r_m_valid & ~m_ready;
    assign s_ready  = ~rst & ~w_stall;
    assign w_accept = s_valid & s_ready;

    assign m_valid  = r_m_valid;
    assign m_pixel  = r_m_pixel;

    // ------------------------------------------------------------------
    // Position of the pixel on the port. A sof beat restarts the frame at
    // (0,0) for that very pixel, so the effective position is muxed here
    // rather than waiting for the counters to be cleared.
    // ------------------------------------------------------------------
    logic [c_col_w-1:0] r_col;
    logic [2:0]         r_row;
    logic [1:0]         r_mode;
    logic [c_col_w-1:0] w_pcol;
    logic [2:0]         w_prow;
    logic [1:0]         w_pmode;
    logic               w_win_ok;

    assign w_pcol   = s_sof ? '0 : r_col;
    assign w_prow   = s_sof ? '0 : r_row;
    assign w_pmode  = s_sof ? mode : r_mode;
    // Rows saturate at 4, so row==4 means "fifth line or later". Columns
    // below 4 would pull window columns from the previous line.
    assign w_win_ok = (w_prow == c_row_full) && (w_pcol >= c_col_four);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_col  <= '0;
            r_row  <= '0;
            r_mode <= 2'b00;
        end else if (w_accept) begin
            if (s_sof) begin
                r_mode <= mode;
            end
            if (w_pcol == c_col_last) begin
                r_col <= '0;
                r_row <= (w_prow == c_row_full) ? c_row_full : w_prow + 3'd1;
            end else begin
                r_col <= w_pcol + c_col_w'(1);
                r_row <= w_prow;
            end
        end
    end

    // ------------------------------------------------------------------
    // Line buffers. Buffer 0 holds the line four rows up, buffer 3 the
    // previous line. Each accept reads all four taps at the current column
    // and writes back the column shifted up by one line.
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] w_tap [4];

    generate
        for (genvar k = 0; k < 4; k++) begin : g_lb
            logic [DATA_W-1:0] r_mem [IMG_W];
            logic [DATA_W-1:0] w_wr;

            assign w_tap[k] = r_mem[w_pcol];

            if (k == 3) begin : g_top
                assign w_wr = s_pixel;
            end else begin : g_mid
                assign w_wr = w_tap[k+1];
            end

            // Contents intentionally survive reset and frame boundaries.
            always_ff @(posedge clk) begin
                if (w_accept) begin
                    r_mem[w_pcol] <= w_wr;
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // 5x5 window: w[r][c], r=0 oldest line, c=0 oldest column.
    // Stage 1 works from the post-shift window so that the kernel sees the
    // new column in the same cycle it is accepted.
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] r_win    [5][5];
    logic [DATA_W-1:0] w_win_nx [5][5];

    always_comb begin
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 4; c++) begin
                w_win_nx[r][c] = r_win[r][c+1];
            end
        end
        for (int r = 0; r < 4; r++) begin
            w_win_nx[r][4] = w_tap[r];
        end
        w_win_nx[4][4] = s_pixel;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < 5; r++) begin
                for (int c = 0; c < 5; c++) begin
                    r_win[r][c] <= '0;
                end
            end
        end else if (w_accept) begin
            r_win <= w_win_nx;
        end
    end

    // ------------------------------------------------------------------
    // Arithmetic helpers
    // ------------------------------------------------------------------
    function automatic logic signed [c_sum_w-1:0] f_ext(input logic [DATA_W-1:0] p);
        return $signed({8'd0, p});
    endfunction

    function automatic logic [DATA_W-1:0] f_sat(input logic signed [c_sum_w-1:0] s);
        logic [c_sum_w-1:0] mag;
        mag = s[c_sum_w-1] ? $unsigned(-s) : $unsigned(s);
        mag = mag >> SHIFT;
        if (mag > c_pix_max) begin
            return c_pix_max[DATA_W-1:0];
        end
        return mag[DATA_W-1:0];
    endfunction

    // ------------------------------------------------------------------
    // Stage 1: per-row partial sums.
    //   X kernel rows share the column weights {-1,-2,0,2,1}.
    //   Y kernel rows share the column weights {1,4,6,4,1}.
    // ------------------------------------------------------------------
    logic signed [c_sum_w-1:0] w_hx [5];
    logic signed [c_sum_w-1:0] w_hy [5];
    logic signed [c_sum_w-1:0] r_hx [5];
    logic signed [c_sum_w-1:0] r_hy [5];
    logic                      r_v1;
    logic [1:0]                r_mode1;

    always_comb begin
        for (int r = 0; r < 5; r++) begin
            w_hx[r] = f_ext(w_win_nx[r][4]) - f_ext(w_win_nx[r][0])
                    + ((f_ext(w_win_nx[r][3]) - f_ext(w_win_nx[r][1])) <<< 1);
            w_hy[r] = f_ext(w_win_nx[r][0]) + f_ext(w_win_nx[r][4])
                    + ((f_ext(w_win_nx[r][1]) + f_ext(w_win_nx[r][3])) <<< 2)
                    + (f_ext(w_win_nx[r][2]) <<< 2)
                    + (f_ext(w_win_nx[r][2]) <<< 1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v1    <= 1'b0;
            r_mode1 <= 2'b00;
            for (int r = 0; r < 5; r++) begin
                r_hx[r] <= '0;
                r_hy[r] <= '0;
            end
        end else if (!w_stall) begin
            r_v1    <= w_accept & w_win_ok;
            r_mode1 <= w_pmode;
            r_hx    <= w_hx;
            r_hy    <= w_hy;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: combine rows.
    //   X: row weights {1,4,6,4,1};  Y: row weights {-1,-2,0,2,1}.
    // ------------------------------------------------------------------
    logic signed [c_sum_w-1:0] w_sx;
    logic signed [c_sum_w-1:0] w_sy;
    logic signed [c_sum_w-1:0] r_sx;
    logic signed [c_sum_w-1:0] r_sy;
    logic                      r_v2;
    logic [1:0]                r_mode2;

    assign w_sx = r_hx[0] + r_hx[4]
                + ((r_hx[1] + r_hx[3]) <<< 2)
                + (r_hx[2] <<< 2) + (r_hx[2] <<< 1);
    assign w_sy = r_hy[4] - r_hy[0] + ((r_hy[3] - r_hy[1]) <<< 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v2    <= 1'b0;
            r_mode2 <= 2'b00;
            r_sx    <= '0;
            r_sy    <= '0;
        end else if (!w_stall) begin
            r_v2    <= r_v1;
            r_mode2 <= r_mode1;
            r_sx    <= w_sx;
            r_sy    <= w_sy;
        end
    end

    // ------------------------------------------------------------------
    // Stage 3: magnitude, shift, saturate, mode select.
    // The mode travels with each sample, so results still draining from a
    // previous frame keep the mode they were accepted under.
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] w_vx;
    logic [DATA_W-1:0] w_vy;
    logic [DATA_W:0]   w_vsum;
    logic [DATA_W-1:0] w_vmag;
    logic [DATA_W-1:0] w_res;

    assign w_vx   = f_sat(r_sx);
    assign w_vy   = f_sat(r_sy);
    assign w_vsum = {1'b0, w_vx} + {1'b0, w_vy};
    assign w_vmag = w_vsum[DATA_W] ? {DATA_W{1'b1}} : w_vsum[DATA_W-1:0];

    always_comb begin
        w_res = w_vx;
        case (r_mode2)
            c_mode_y:   w_res = w_vy;
            c_mode_mag: w_res = w_vmag;
            default:    w_res = w_vx;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_m_valid <= 1'b0;
            r_m_pixel <= '0;
        end else if (!w_stall) begin
            r_m_valid <= r_v2;
            if (r_v2) begin
                r_m_pixel <= w_res;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sobel_stream_5x5.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sobel_stream_5x5
//  Description : Directed and randomised checks of sobel_stream_5x5 with a
//                16-pixel line: flat, ramp, step and diagonal frames, random
//                back-pressure, reset mid-frame and mode latching.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sobel_stream_5x5;

    localparam int W    = 16;
    localparam int HMAX = 8;
    localparam int BIG  = 1 << 30;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] mode = 2'b00;
    logic       s_valid = 1'b0;
    logic       s_ready;
    logic       s_sof = 1'b0;
    logic [7:0] s_pixel = 8'd0;
    logic       m_valid;
    logic       m_ready = 1'b1;
    logic [7:0] m_pixel;

    int total = 0;
    int bad   = 0;

    int img [2][HMAX][W];
    int kr [5] = '{1, 4, 6, 4, 1};
    int kc [5] = '{-1, -2, 0, 2, 1};

    typedef struct {
        bit         sof;
        logic [7:0] pix;
        logic [1:0] md;
    } item_t;

    item_t      inq [$];
    logic [7:0] got [$];

    sobel_stream_5x5 #(
        .DATA_W (8),
        .IMG_W  (W),
        .SHIFT  (4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .mode    (mode),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_sof   (s_sof),
        .s_pixel (s_pixel),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_pixel (m_pixel)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Direct 5x5 convolution over a stored frame.
    function automatic int ref_pix(int f, int md, int x, int y);
        int sx = 0;
        int sy = 0;
        int vx, vy, p;
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 5; c++) begin
                p  = img[f][y-4+r][x-4+c];
                sx += kr[r] * kc[c] * p;
                sy += kc[r] * kr[c] * p;
            end
        end
        if (sx < 0) sx = -sx;
        if (sy < 0) sy = -sy;
        vx = ((sx >> 4) > 255) ? 255 : (sx >> 4);
        vy = ((sy >> 4) > 255) ? 255 : (sy >> 4);
        if (md == 1) return vy;
        if (md == 2) return ((vx + vy) > 255) ? 255 : (vx + vy);
        return vx;
    endfunction

    // kind: 0 flat 100, 1 ramp=col, 2 vertical step, 3 diagonal step, 4 random
    task automatic fill_frame(input int f, input int h, input int kind);
        for (int y = 0; y < h; y++) begin
            for (int x = 0; x < W; x++) begin
                case (kind)
                    0:       img[f][y][x] = 100;
                    1:       img[f][y][x] = x;
                    2:       img[f][y][x] = (x < 8) ? 0 : 255;
                    3:       img[f][y][x] = (x >= y + 5) ? 255 : 0;
                    default: img[f][y][x] = int'($urandom_range(255));
                endcase
            end
        end
    endtask

    task automatic enqueue_frame(input int f, input int h, input logic [1:0] md_sof,
                                 input logic [1:0] md_rest, input int limit);
        int    n;
        item_t it;
        n = 0;
        for (int y = 0; y < h; y++) begin
            for (int x = 0; x < W; x++) begin
                if (n < limit) begin
                    it.sof = (y == 0 && x == 0);
                    it.pix = 8'(img[f][y][x]);
                    it.md  = (n == 0) ? md_sof : md_rest;
                    inq.push_back(it);
                end
                n++;
            end
        end
    endtask

    // Drives the queued pixels, collects accepted outputs into got and
    // tallies handshake observations for the calling test to judge.
    task automatic run_stream(input int gap_pct, input int lo_pct, input int probe_idx,
                              input int tail_cycles, output bit timeout,
                              output int stall_bad, output int sready_bad,
                              output int probe_acc, output int first_out);
        int         idx, iter, tail, budget;
        bit         acc, stall, prev_stall;
        logic [7:0] prev_pix;
        idx = 0; iter = 0; tail = 0;
        acc = 1'b1; prev_stall = 1'b0; prev_pix = 8'd0;
        timeout = 1'b0; stall_bad = 0; sready_bad = 0;
        probe_acc = -1; first_out = -1;
        budget = 10 * inq.size() + 100;
        while (inq.size() > 0 || tail < tail_cycles) begin
            @(posedge clk);
            #1;
            if (acc || !s_valid) begin
                if (inq.size() > 0 && int'($urandom_range(99)) >= gap_pct) begin
                    s_valid = 1'b1;
                    s_sof   = inq[0].sof;
                    s_pixel = inq[0].pix;
                    mode    = inq[0].md;
                end else begin
                    s_valid = 1'b0;
                    s_sof   = 1'b0;
                end
            end
            m_ready = (inq.size() == 0) ? 1'b1 : (int'($urandom_range(99)) >= lo_pct);
            @(negedge clk);
            stall = m_valid && !m_ready;
            if (s_ready !== !stall) sready_bad++;
            if (prev_stall && (m_valid !== 1'b1 || m_pixel !== prev_pix)) stall_bad++;
            if (m_valid === 1'b1 && first_out < 0) first_out = iter;
            if (m_valid === 1'b1 && m_ready) got.push_back(m_pixel);
            acc = s_valid && s_ready;
            if (acc) begin
                if (idx == probe_idx) probe_acc = iter;
                idx++;
                inq.delete(0);
            end
            if (inq.size() == 0) tail++;
            prev_stall = stall;
            prev_pix   = m_pixel;
            iter++;
            if (iter > budget) begin
                timeout = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        total++;
        if (s_ready !== 1'b0) begin bad++; $display("FAIL reset_s_ready: got %b want 0", s_ready); end
        total++;
        if (m_valid !== 1'b0) begin bad++; $display("FAIL reset_m_valid: got %b want 0", m_valid); end
        total++;
        if (m_pixel !== 8'd0) begin bad++; $display("FAIL reset_m_pixel: got %0d want 0", m_pixel); end
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        total++;
        if (s_ready !== 1'b1) begin bad++; $display("FAIL release_s_ready: got %b want 1", s_ready); end
        total++;
        if (m_valid !== 1'b0) begin bad++; $display("FAIL release_m_valid: got %b want 0", m_valid); end
    endtask

    task automatic test_constant();
        bit to;
        int sb, rb, pa, fo;
        fill_frame(0, 6, 0);
        for (int md = 0; md < 3; md++) begin
            got.delete();
            enqueue_frame(0, 6, 2'(md), 2'(md), BIG);
            run_stream(0, 0, -1, 10, to, sb, rb, pa, fo);
            total++;
            if (to) begin bad++; $display("FAIL const_timeout: mode %0d got timeout want none", md); end
            total++;
            if (got.size() != 24) begin bad++; $display("FAIL const_count: mode %0d got %0d want 24", md, got.size()); end
            for (int i = 0; i < got.size(); i++) begin
                total++;
                if (got[i] !== 8'd0) begin bad++; $display("FAIL const_pix: mode %0d idx %0d got %0d want 0", md, i, got[i]); end
            end
        end
    endtask

    task automatic test_hramp();
        bit         to;
        int         sb, rb, pa, fo;
        logic [7:0] want;
        fill_frame(0, 6, 1);
        for (int md = 0; md < 2; md++) begin
            want = (md == 0) ? 8'd8 : 8'd0;
            got.delete();
            enqueue_frame(0, 6, 2'(md), 2'(md), BIG);
            run_stream(0, 0, -1, 10, to, sb, rb, pa, fo);
            total++;
            if (got.size() != 24) begin bad++; $display("FAIL hramp_count: mode %0d got %0d want 24", md, got.size()); end
            for (int i = 0; i < got.size(); i++) begin
                total++;
                if (got[i] !== want) begin bad++; $display("FAIL hramp_pix: mode %0d idx %0d got %0d want %0d", md, i, got[i], want); end
            end
        end
    endtask

    task automatic test_vstep();
        bit         to;
        int         sb, rb, pa, fo, x;
        logic [7:0] want;
        fill_frame(0, 6, 2);
        got.delete();
        enqueue_frame(0, 6, 2'b00, 2'b00, BIG);
        run_stream(0, 0, -1, 10, to, sb, rb, pa, fo);
        total++;
        if (got.size() != 24) begin bad++; $display("FAIL vstep_count: got %0d want 24", got.size()); end
        for (int i = 0; i < got.size(); i++) begin
            x    = 4 + (i % 12);
            want = (x >= 8 && x <= 11) ? 8'd255 : 8'd0;
            total++;
            if (got[i] !== want) begin bad++; $display("FAIL vstep_pix: x %0d got %0d want %0d", x, got[i], want); end
        end
    endtask

    task automatic test_diag_mag();
        bit         to;
        int         sb, rb, pa, fo;
        logic [7:0] want;
        fill_frame(0, 8, 3);
        got.delete();
        enqueue_frame(0, 8, 2'b10, 2'b10, BIG);
        run_stream(0, 0, -1, 10, to, sb, rb, pa, fo);
        total++;
        if (got.size() != 48) begin bad++; $display("FAIL diag_count: got %0d want 48", got.size()); end
        for (int i = 0; i < got.size(); i++) begin
            want = 8'(ref_pix(0, 2, 4 + (i % 12), 4 + (i / 12)));
            total++;
            if (got[i] !== want) begin bad++; $display("FAIL diag_pix: idx %0d got %0d want %0d", i, got[i], want); end
        end
    endtask

    // Two random frames back to back under random gaps and back-pressure;
    // the second frame's sof changes mode while the first still drains.
    task automatic test_back_to_back();
        bit         to;
        int         sb, rb, pa, fo, f, md, k;
        logic [7:0] want;
        fill_frame(0, 8, 4);
        fill_frame(1, 8, 4);
        got.delete();
        enqueue_frame(0, 8, 2'b10, 2'b10, BIG);
        enqueue_frame(1, 8, 2'b01, 2'b01, BIG);
        run_stream(25, 30, -1, 12, to, sb, rb, pa, fo);
        total++;
        if (to) begin bad++; $display("FAIL random_timeout: got timeout want none"); end
        total++;
        if (sb != 0) begin bad++; $display("FAIL random_stall_hold: got %0d unstable stalled cycles want 0", sb); end
        total++;
        if (rb != 0) begin bad++; $display("FAIL random_s_ready: got %0d wrong s_ready cycles want 0", rb); end
        total++;
        if (got.size() != 96) begin bad++; $display("FAIL random_count: got %0d want 96", got.size()); end
        for (int i = 0; i < got.size(); i++) begin
            f    = (i < 48) ? 0 : 1;
            md   = (i < 48) ? 2 : 1;
            k    = i % 48;
            want = 8'(ref_pix(f, md, 4 + (k % 12), 4 + (k / 12)));
            total++;
            if (got[i] !== want) begin bad++; $display("FAIL random_pix: idx %0d got %0d want %0d", i, got[i], want); end
        end
    endtask

    task automatic test_reset_mid();
        bit to;
        int sb, rb, pa, fo;
        fill_frame(0, 8, 1);
        got.delete();
        // Stop right after row 6, col 5, with results still in the pipeline.
        enqueue_frame(0, 8, 2'b00, 2'b00, 6 * W + 6);
        run_stream(0, 0, -1, 0, to, sb, rb, pa, fo);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_sof   = 1'b0;
        rst     = 1'b1;
        @(negedge clk);
        total++;
        if (m_valid !== 1'b0) begin bad++; $display("FAIL rstmid_m_valid0: got %b want 0", m_valid); end
        total++;
        if (s_ready !== 1'b0) begin bad++; $display("FAIL rstmid_s_ready: got %b want 0", s_ready); end
        @(posedge clk);
        #1;
        @(negedge clk);
        total++;
        if (m_valid !== 1'b0) begin bad++; $display("FAIL rstmid_m_valid1: got %b want 0", m_valid); end
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        total++;
        if (m_valid !== 1'b0) begin bad++; $display("FAIL rstmid_m_valid2: got %b want 0", m_valid); end
        got.delete();
        enqueue_frame(0, 8, 2'b00, 2'b00, BIG);
        run_stream(0, 0, 4 * W + 4, 10, to, sb, rb, pa, fo);
        total++;
        if (fo - pa != 3) begin bad++; $display("FAIL rstmid_latency: got %0d want 3 (acc %0d out %0d)", fo - pa, pa, fo); end
        total++;
        if (got.size() != 48) begin bad++; $display("FAIL rstmid_count: got %0d want 48", got.size()); end
        for (int i = 0; i < got.size(); i++) begin
            total++;
            if (got[i] !== 8'd8) begin bad++; $display("FAIL rstmid_pix: idx %0d got %0d want 8", i, got[i]); end
        end
    endtask

    task automatic test_mode_ignore();
        bit         to;
        int         sb, rb, pa, fo;
        logic [1:0] md_sof  [3] = '{2'b00, 2'b01, 2'b10};
        logic [1:0] md_rest [3] = '{2'b01, 2'b00, 2'b01};
        logic [7:0] want    [3] = '{8'd8, 8'd0, 8'd8};
        fill_frame(0, 6, 1);
        for (int t = 0; t < 3; t++) begin
            got.delete();
            enqueue_frame(0, 6, md_sof[t], md_rest[t], BIG);
            run_stream(0, 0, -1, 10, to, sb, rb, pa, fo);
            total++;
            if (got.size() != 24) begin bad++; $display("FAIL mode_count: case %0d got %0d want 24", t, got.size()); end
            for (int i = 0; i < got.size(); i++) begin
                total++;
                if (got[i] !== want[t]) begin bad++; $display("FAIL mode_pix: case %0d idx %0d got %0d want %0d", t, i, got[i], want[t]); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_constant();
        test_hramp();
        test_vstep();
        test_diag_mag();
        test_back_to_back();
        test_reset_mid();
        test_mode_ignore();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
